// File: rtl/regfile_mp.sv
// Multi-port register file with a power-up/reset clear sequence, same-cycle
// write forwarding and a per-register pending scoreboard.
module regfile_mp #(
    parameter int N        = 32,
    parameter int W        = 32,
    parameter int NR       = 2,
    parameter int NW       = 2,
    parameter int ZERO_REG = 0,
    parameter int FWD      = 1,
    localparam int AW      = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NW-1:0]         wen,
    input  logic [NW-1:0][AW-1:0] waddr,
    input  logic [NW-1:0][W-1:0]  wdata,
    input  logic [NR-1:0][AW-1:0] raddr,
    output logic [NR-1:0][W-1:0]  rdata,
    output logic [NR-1:0]         rpend,
    input  logic                  set_en,
    input  logic [AW-1:0]         set_addr,
    output logic                  ready
);

    localparam logic [AW-1:0] ZA   = AW'(ZERO_REG);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic [W-1:0]  regs [N];
    logic [N-1:0]  pending;
    logic [NW-1:0] wr_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            INIT: begin
                idx_nxt = idx + 1'b1;
                if (idx == LAST) begin
                    state_nxt = RUN;
                    idx_nxt   = '0;
                end
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    assign ready = (state == RUN);

    // A write is only accepted in RUN and never in a reset cycle.
    always_comb begin
        for (int k = 0; k < NW; k++) begin
            wr_acc[k] = ready && !rst && wen[k] && (waddr[k] != ZA);
        end
    end

    // Later ports are assigned last, so the highest-index port wins a collision.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            regs[idx] <= '0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (wr_acc[k]) regs[waddr[k]] <= wdata[k];
            end
        end
    end

    // Set is applied after the write-clears so it wins on the same address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else if (ready) begin
            for (int k = 0; k < NW; k++) begin
                if (wr_acc[k]) pending[waddr[k]] <= 1'b0;
            end
            if (set_en && set_addr != ZA) pending[set_addr] <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            rdata[i] = '0;
            rpend[i] = 1'b0;
            if (ready && raddr[i] != ZA) begin
                rdata[i] = regs[raddr[i]];
                rpend[i] = pending[raddr[i]];
                if (FWD != 0) begin
                    for (int k = 0; k < NW; k++) begin
                        if (wr_acc[k] && waddr[k] == raddr[i]) begin
                            rdata[i] = wdata[k];
                            rpend[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one forwarding and one non-forwarding
// instance share all stimulus; each has its own expected values.
module tb_regfile_mp;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       wen;
    logic [1:0][4:0]  waddr;
    logic [1:0][31:0] wdata;
    logic [1:0][4:0]  raddr;
    logic             set_en;
    logic [4:0]       set_addr;

    logic [1:0][31:0] rdata_f1, rdata_f0;
    logic [1:0]       rpend_f1, rpend_f0;
    logic             ready_f1, ready_f0;

    int n_cmp  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    regfile_mp #(.FWD(1)) u_dut_f1 (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_f1), .rpend(rpend_f1),
        .set_en(set_en), .set_addr(set_addr), .ready(ready_f1)
    );

    regfile_mp #(.FWD(0)) u_dut_f0 (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_f0), .rpend(rpend_f0),
        .set_en(set_en), .set_addr(set_addr), .ready(ready_f0)
    );

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        set_en;
        logic [4:0]  sa;
        logic [31:0] e1_rd0;
        logic [31:0] e1_rd1;
        logic [1:0]  e1_rp;
        logic [31:0] e0_rd0;
        logic [31:0] e0_rd1;
        logic [1:0]  e0_rp;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        wen      = '0;
        waddr    = '0;
        wdata    = '0;
        raddr    = '0;
        set_en   = 1'b0;
        set_addr = '0;
    endtask

    // Entered and left on a negedge; rst covers exactly one posedge.
    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called right after pulse_rst: ready must stay low 32 cycles and rise on the 33rd.
    task automatic check_ready_rise(input string tag, input bit with_writes);
        for (int c = 1; c <= 33; c++) begin
            drive_idle();
            if (with_writes && c < 33) begin
                wen      = 2'b11;
                waddr[0] = 5'($urandom_range(0, 31));
                waddr[1] = 5'($urandom_range(0, 31));
                wdata[0] = $urandom;
                wdata[1] = $urandom;
                raddr[0] = 5'($urandom_range(1, 31));
                raddr[1] = 5'($urandom_range(1, 31));
                set_en   = 1'b1;
                set_addr = 5'($urandom_range(1, 31));
            end
            #1;
            chk($sformatf("%s_ready_f1_c%0d", tag, c), 32'(ready_f1), 32'(c == 33));
            chk($sformatf("%s_ready_f0_c%0d", tag, c), 32'(ready_f0), 32'(c == 33));
            if (with_writes && c < 33) begin
                chk($sformatf("%s_init_rd_c%0d", tag, c), rdata_f1[0] | rdata_f1[1], 32'h0);
                chk($sformatf("%s_init_rp_c%0d", tag, c), 32'({rpend_f1, rpend_f0}), 32'h0);
            end
            @(negedge clk);
        end
        drive_idle();
    endtask

    initial begin
        vecs[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0,
                     32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0, 32'h0, 2'b00};
        vecs[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0, 5'd0,
                     32'h0, 32'hDEADBEEF, 2'b00, 32'h0, 32'hDEADBEEF, 2'b00};
        vecs[2]  = '{2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0,
                     32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
        vecs[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0, 5'd0,
                     32'h0, 32'hDEADBEEF, 2'b00, 32'h0, 32'hDEADBEEF, 2'b00};
        vecs[4]  = '{2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222, 5'd7, 5'd5, 1'b0, 5'd0,
                     32'h2222, 32'hDEADBEEF, 2'b00, 32'h0, 32'hDEADBEEF, 2'b00};
        vecs[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0,
                     32'h2222, 32'h2222, 2'b00, 32'h2222, 32'h2222, 2'b00};
        vecs[6]  = '{2'b01, 5'd3, 32'hA5, 5'd0, 32'h0, 5'd3, 5'd7, 1'b0, 5'd0,
                     32'hA5, 32'h2222, 2'b00, 32'h0, 32'h2222, 2'b00};
        vecs[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd5, 1'b0, 5'd0,
                     32'hA5, 32'hDEADBEEF, 2'b00, 32'hA5, 32'hDEADBEEF, 2'b00};
        vecs[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9,
                     32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
        vecs[9]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0,
                     32'h0, 32'h0, 2'b11, 32'h0, 32'h0, 2'b11};
        vecs[10] = '{2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 5'd9, 5'd3, 1'b1, 5'd9,
                     32'h99, 32'hA5, 2'b00, 32'h0, 32'hA5, 2'b01};
        vecs[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0,
                     32'h99, 32'h99, 2'b11, 32'h99, 32'h99, 2'b11};
        vecs[12] = '{2'b10, 5'd0, 32'h0, 5'd9, 32'h77, 5'd9, 5'd5, 1'b0, 5'd0,
                     32'h77, 32'hDEADBEEF, 2'b00, 32'h99, 32'hDEADBEEF, 2'b01};
        vecs[13] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0,
                     32'h77, 32'h77, 2'b00, 32'h77, 32'h77, 2'b00};
        vecs[14] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b1, 5'd0,
                     32'h0, 32'h77, 2'b00, 32'h0, 32'h77, 2'b00};
        vecs[15] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0,
                     32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
        vecs[16] = '{2'b11, 5'd4, 32'h44, 5'd6, 32'h66, 5'd4, 5'd6, 1'b0, 5'd0,
                     32'h44, 32'h66, 2'b00, 32'h0, 32'h0, 2'b00};
        vecs[17] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd6, 1'b0, 5'd0,
                     32'h44, 32'h66, 2'b00, 32'h44, 32'h66, 2'b00};

        // Power-up reset, with writes and sets hammered throughout INIT.
        drive_idle();
        pulse_rst();
        check_ready_rise("por", 1'b1);

        for (int r = 0; r < 16; r++) begin
            raddr[0] = 5'(2 * r);
            raddr[1] = 5'(2 * r + 1);
            #1;
            chk($sformatf("zero_rd0_x%0d", 2 * r), rdata_f1[0], 32'h0);
            chk($sformatf("zero_rd1_x%0d", 2 * r + 1), rdata_f1[1], 32'h0);
            chk($sformatf("zero_f0_x%0d", 2 * r), rdata_f0[0] | rdata_f0[1], 32'h0);
            chk($sformatf("zero_rp_x%0d", 2 * r), 32'({rpend_f1, rpend_f0}), 32'h0);
            @(negedge clk);
        end

        for (int i = 0; i < 18; i++) begin
            wen      = vecs[i].wen;
            waddr[0] = vecs[i].wa0;
            wdata[0] = vecs[i].wd0;
            waddr[1] = vecs[i].wa1;
            wdata[1] = vecs[i].wd1;
            raddr[0] = vecs[i].ra0;
            raddr[1] = vecs[i].ra1;
            set_en   = vecs[i].set_en;
            set_addr = vecs[i].sa;
            #1;
            chk($sformatf("v%0d_rd0_f1", i), rdata_f1[0], vecs[i].e1_rd0);
            chk($sformatf("v%0d_rd1_f1", i), rdata_f1[1], vecs[i].e1_rd1);
            chk($sformatf("v%0d_rp_f1", i), 32'(rpend_f1), 32'(vecs[i].e1_rp));
            chk($sformatf("v%0d_rd0_f0", i), rdata_f0[0], vecs[i].e0_rd0);
            chk($sformatf("v%0d_rd1_f0", i), rdata_f0[1], vecs[i].e0_rd1);
            chk($sformatf("v%0d_rp_f0", i), 32'(rpend_f0), 32'(vecs[i].e0_rp));
            @(negedge clk);
        end

        // Mark x12 pending, then reset mid-RUN with a write presented in the reset cycle.
        drive_idle();
        set_en   = 1'b1;
        set_addr = 5'd12;
        @(negedge clk);
        drive_idle();
        raddr[0] = 5'd12;
        #1;
        chk("x12_pending_before_rst", 32'(rpend_f1[0]), 32'h1);
        wen      = 2'b01;
        waddr[0] = 5'd20;
        wdata[0] = 32'h55;
        pulse_rst();
        drive_idle();
        for (int c = 1; c <= 9; c++) begin
            #1;
            chk($sformatf("midrun_ready_c%0d", c), 32'({ready_f1, ready_f0}), 32'h0);
            @(negedge clk);
        end

        // Second reset lands on init cycle 10; the full clear must restart.
        pulse_rst();
        check_ready_rise("midinit", 1'b0);

        raddr[0] = 5'd5;
        raddr[1] = 5'd12;
        #1;
        chk("post_rst_x5_f1", rdata_f1[0], 32'h0);
        chk("post_rst_x5_f0", rdata_f0[0], 32'h0);
        chk("post_rst_x12_rp", 32'({rpend_f1[1], rpend_f0[1]}), 32'h0);
        @(negedge clk);
        raddr[0] = 5'd20;
        raddr[1] = 5'd7;
        #1;
        chk("post_rst_x20", rdata_f1[0] | rdata_f0[0], 32'h0);
        chk("post_rst_x7", rdata_f1[1] | rdata_f0[1], 32'h0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
